// File: rtl/win_pkg.sv
// Shared encodings for the window scanner: line directions, FSM states, cell indexing.
// Pure declarations; no logic, no latency, no flow control.
package win_pkg;

    localparam logic [1:0] DIR_H = 2'd0;
    localparam logic [1:0] DIR_V = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_A = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/win_scanner_if.sv
// Request/result bundle between game-state register, scanner and game-control FSM.
// start is only honoured while busy is low; results hold until the next accepted start.
interface win_scanner_if #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int CELL_W = 2
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                          start;
    logic [ROWS*COLS*CELL_W-1:0]   board;
    logic [CELL_W-1:0]             player_id;
    logic                          busy;
    logic                          done;
    logic                          player_won;
    logic [1:0]                    win_dir;
    logic [RW-1:0]                 win_row;
    logic [CW-1:0]                 win_col;

    modport master (
        output start, board, player_id,
        input  busy, done, player_won, win_dir, win_row, win_col
    );

    modport slave (
        input  start, board, player_id,
        output busy, done, player_won, win_dir, win_row, win_col
    );

endinterface

// File: rtl/win_line_match.sv
// Combinational check of the four lines starting at anchor (r,c); lines leaving the board never match.
// Zero latency, no flow control.
module win_line_match
    import win_pkg::*;
#(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int WIN_LEN = 4,
    parameter int CELL_W  = 2,
    parameter int RW      = 3,
    parameter int CW      = 3
) (
    input  logic [ROWS*COLS*CELL_W-1:0] board,
    input  logic [CELL_W-1:0]           player_id,
    input  logic [RW-1:0]               r,
    input  logic [CW-1:0]               c,
    output logic [3:0]                  match
);
    localparam int BW = ROWS * COLS * CELL_W;
    localparam int IW = (BW > 1) ? $clog2(BW) : 1;

    // Off-board cells are rejected before the board is indexed, so the select stays in range.
    function automatic logic line_ok(input logic [BW-1:0] b, input logic [CELL_W-1:0] p,
                                     input int r0, input int c0, input int dr, input int dc);
        logic           ok;
        int             rr;
        int             cc;
        logic [IW-1:0]  bidx;
        ok   = (p != '0);
        bidx = '0;
        for (int i = 0; i < WIN_LEN; i++) begin
            rr = r0 + i * dr;
            cc = c0 + i * dc;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                ok = 1'b0;
            end else begin
                bidx = IW'(cell_idx(rr, cc, COLS) * CELL_W);
                if (b[bidx +: CELL_W] != p) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign match[DIR_H] = line_ok(board, player_id, int'(r), int'(c), 0,  1);
    assign match[DIR_V] = line_ok(board, player_id, int'(r), int'(c), 1,  0);
    assign match[DIR_D] = line_ok(board, player_id, int'(r), int'(c), 1,  1);
    assign match[DIR_A] = line_ok(board, player_id, int'(r), int'(c), 1, -1);

endmodule

// File: rtl/win_scanner.sv
// Scans a latched board one anchor per cycle for a WIN_LEN run of player_id; done pulses at t+2+k (win) or t+1+ROWS*COLS.
// start is ignored while busy; no output backpressure, result registers hold until the next accepted start.
module win_scanner
    import win_pkg::*;
#(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int WIN_LEN = 4,
    parameter int CELL_W  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    win_scanner_if.slave bus
);
    localparam int BW = ROWS * COLS * CELL_W;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t            state,   state_nxt;
    logic [BW-1:0]     board_q, board_nxt;
    logic [CELL_W-1:0] pid_q,   pid_nxt;
    logic [RW-1:0]     r_q,     r_nxt;
    logic [CW-1:0]     c_q,     c_nxt;
    logic              won_q,   won_nxt;
    logic [1:0]        dir_q,   dir_nxt;
    logic [RW-1:0]     row_q,   row_nxt;
    logic [CW-1:0]     col_q,   col_nxt;
    logic [3:0]        match;

    win_line_match #(
        .ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN), .CELL_W(CELL_W), .RW(RW), .CW(CW)
    ) u_match (
        .board     (board_q),
        .player_id (pid_q),
        .r         (r_q),
        .c         (c_q),
        .match     (match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            board_q <= '0;
            pid_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            won_q   <= 1'b0;
            dir_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state   <= state_nxt;
            board_q <= board_nxt;
            pid_q   <= pid_nxt;
            r_q     <= r_nxt;
            c_q     <= c_nxt;
            won_q   <= won_nxt;
            dir_q   <= dir_nxt;
            row_q   <= row_nxt;
            col_q   <= col_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        board_nxt = board_q;
        pid_nxt   = pid_q;
        r_nxt     = r_q;
        c_nxt     = c_q;
        won_nxt   = won_q;
        dir_nxt   = dir_q;
        row_nxt   = row_q;
        col_nxt   = col_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    board_nxt = bus.board;
                    pid_nxt   = bus.player_id;
                    won_nxt   = 1'b0;
                    dir_nxt   = '0;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    r_nxt     = '0;
                    c_nxt     = '0;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (|match) begin
                    won_nxt   = 1'b1;
                    dir_nxt   = match[DIR_H] ? DIR_H :
                                match[DIR_V] ? DIR_V :
                                match[DIR_D] ? DIR_D : DIR_A;
                    row_nxt   = r_q;
                    col_nxt   = c_q;
                    state_nxt = ST_DONE;
                end else if (r_q == RW'(ROWS - 1) && c_q == CW'(COLS - 1)) begin
                    state_nxt = ST_DONE;
                end else if (c_q == CW'(COLS - 1)) begin
                    c_nxt = '0;
                    r_nxt = r_q + RW'(1);
                end else begin
                    c_nxt = c_q + CW'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.player_won = won_q;
    assign bus.win_dir    = dir_q;
    assign bus.win_row    = row_q;
    assign bus.win_col    = col_q;

endmodule
